fp_compare_seq: RTL

Multi-cycle floating-point compare sequencer that issues operand pairs to the single-precision magnitude comparator and interprets its 3-bit result. It adds IEEE-754 fixups the comparator lacks (NaN/unordered, ±0 equality), updates the FPU condition flag (FCC) for `c.cond.s`, and answers `bc1t`/`bc1f` branch queries. It sits between the decode/issue stage and the comparator, acting as the initiator side of the comparator interface.

---
 rtl/fp_compare_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fp_compare_seq.sv
// Three-state compare sequencer around a single-precision magnitude comparator.
// It adds the NaN and signed-zero fixups, and it owns the FCC flag, the sticky invalid flag and the bc1t/bc1f answer.
module fp_compare_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cond,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] cmp_num1,
  output logic [31:0] cmp_num2,
  input  logic [2:0]  cmp_result,
  output logic        done,
  output logic        fcc,
  output logic        exception,
  input  logic        exc_clear,
  input  logic        br_true,
  output logic        br_taken,
  output logic        br_stall
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EVAL} state_t;

  localparam logic [1:0] C_EQ = 2'b00;
  localparam logic [1:0] C_LT = 2'b01;
  localparam logic [1:0] C_LE = 2'b10;
  localparam logic [1:0] C_UN = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] num1_q, num1_d, num2_q, num2_d;
  logic [1:0]  cond_q, cond_d;
  logic        nan_q, nan_d, zero_q, zero_d;
  logic        fcc_q, fcc_d, exc_q, exc_d, done_q, done_d;

  logic rel_un, rel_eq, rel_lt, rel_ill, fcc_res, exc_set;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Resolve the relation in priority order: unordered, then signed zero, then the comparator code.
  always_comb begin
    rel_un  = nan_q;
    rel_eq  = 1'b0;
    rel_lt  = 1'b0;
    rel_ill = 1'b0;
    if (!nan_q) begin
      if (zero_q) rel_eq = 1'b1;
      else begin
        case (cmp_result)
          3'b100:  ;
          3'b010:  rel_eq = 1'b1;
          3'b001:  rel_lt = 1'b1;
          default: rel_ill = 1'b1;
        endcase
      end
    end
    case (cond_q)
      C_EQ:    fcc_res = rel_eq;
      C_LT:    fcc_res = rel_lt;
      C_LE:    fcc_res = rel_lt | rel_eq;
      default: fcc_res = rel_un;
    endcase
    exc_set = rel_ill | (rel_un & ((cond_q == C_LT) | (cond_q == C_LE)));
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    cond_d  = cond_q;
    nan_d   = nan_q;
    zero_d  = zero_q;
    fcc_d   = fcc_q;
    done_d  = 1'b0;
    exc_d   = exc_q & ~exc_clear;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_ISSUE;
        num1_d  = req_a;
        num2_d  = req_b;
        cond_d  = req_cond;
        nan_d   = is_nan(req_a) | is_nan(req_b);
        zero_d  = (req_a[30:0] == 31'd0) && (req_b[30:0] == 31'd0);
      end
      S_ISSUE: state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        fcc_d   = fcc_res;
        // A new set beats a clear arriving on the same edge.
        if (exc_set) exc_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      num1_q  <= '0;
      num2_q  <= '0;
      cond_q  <= C_EQ;
      nan_q   <= 1'b0;
      zero_q  <= 1'b0;
      fcc_q   <= 1'b0;
      exc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cond_q  <= cond_d;
      nan_q   <= nan_d;
      zero_q  <= zero_d;
      fcc_q   <= fcc_d;
      exc_q   <= exc_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign br_stall  = (state_q != S_IDLE);
  assign cmp_num1  = num1_q;
  assign cmp_num2  = num2_q;
  assign done      = done_q;
  assign fcc       = fcc_q;
  assign exception = exc_q;
  assign br_taken  = br_true ? fcc_q : ~fcc_q;
endmodule
